traffic_ctrl_param: RTL

Parametrised four-approach intersection controller. It generalises the fixed 68-cycle, per-approach traffic block into one shared phase state machine. It adds configurable phase lengths, on-demand pedestrian service, night flashing mode and emergency all-red preemption. It sits at the top of the traffic subsystem and drives the north/south (NS) and east/west (EW) car and pedestrian heads directly.

---
 rtl/traffic_ctrl_param.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_ctrl_param.sv
// Four-approach intersection controller: shared NS/EW phase FSM with
// configurable phase lengths, on-demand pedestrian service, night flashing
// and emergency all-red preemption.
module traffic_ctrl_param #(
  parameter int unsigned GREEN_LEN     = 14,
  parameter int unsigned BLINK_LEN     = 6,
  parameter int unsigned YELLOW_LEN    = 2,
  parameter int unsigned LEFT_LEN      = 10,
  parameter int unsigned ALLRED_LEN    = 2,
  parameter int unsigned FLASH_LEN     = 4,
  parameter int unsigned TICK_W        = 8,
  parameter bit          PED_ON_DEMAND = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_ped_req,
  input  logic              i_night,
  input  logic              i_emg,
  output logic [1:0]        o_ns_car,
  output logic [1:0]        o_ew_car,
  output logic [1:0]        o_ns_ped,
  output logic [1:0]        o_ew_ped,
  output logic [3:0]        o_state,
  output logic [TICK_W-1:0] o_tick,
  output logic [1:0]        o_ped_pending
);

  typedef enum logic [3:0] {
    NS_GRN  = 4'd0,
    NS_BLK  = 4'd1,
    NS_Y1   = 4'd2,
    NS_LFT  = 4'd3,
    NS_Y2   = 4'd4,
    EW_GRN  = 4'd5,
    EW_BLK  = 4'd6,
    EW_Y1   = 4'd7,
    EW_LFT  = 4'd8,
    EW_Y2   = 4'd9,
    ALL_RED = 4'd10,
    FLASH   = 4'd11
  } state_t;

  localparam logic [1:0] CAR_RED    = 2'b00;
  localparam logic [1:0] CAR_GREEN  = 2'b01;
  localparam logic [1:0] CAR_YELLOW = 2'b10;
  localparam logic [1:0] CAR_LEFT   = 2'b11;
  localparam logic [1:0] PED_RED    = 2'b00;
  localparam logic [1:0] PED_GREEN  = 2'b01;
  localparam logic [1:0] PED_BLINK  = 2'b10;

  localparam logic [TICK_W-1:0] TICK_ONE     = TICK_W'(1);
  localparam logic [TICK_W-1:0] GREEN_T      = TICK_W'(GREEN_LEN);
  localparam logic [TICK_W-1:0] BLINK_T      = TICK_W'(BLINK_LEN);
  localparam logic [TICK_W-1:0] YELLOW_T     = TICK_W'(YELLOW_LEN);
  localparam logic [TICK_W-1:0] LEFT_T       = TICK_W'(LEFT_LEN);
  localparam logic [TICK_W-1:0] ALLRED_T     = TICK_W'(ALLRED_LEN);
  localparam logic [TICK_W-1:0] FLASH_HALF_T = TICK_W'(FLASH_LEN);
  localparam logic [TICK_W-1:0] FLASH_END_T  = TICK_W'(2 * FLASH_LEN);

  localparam logic AXIS_NS = 1'b0;
  localparam logic AXIS_EW = 1'b1;

  // Without on-demand service every crossing is always served
  localparam logic SRV_DEFAULT = ~PED_ON_DEMAND;

  state_t            state, state_d;
  logic [TICK_W-1:0] tick, tick_d;
  logic [1:0]        pending, pending_d;
  logic              last_axis, last_axis_d;
  logic              srv_ew, srv_ew_d;   // EW crossing shown during NS green
  logic              srv_ns, srv_ns_d;   // NS crossing shown during EW green
  logic [TICK_W-1:0] state_len;
  logic              done;
  logic              preempt;
  logic              cur_axis;

  // Length of the current state and phase-complete flag
  always_comb begin
    state_len = TICK_ONE;
    case (state)
      NS_GRN, EW_GRN:               state_len = GREEN_T;
      NS_BLK, EW_BLK:               state_len = BLINK_T;
      NS_Y1, EW_Y1, NS_Y2, EW_Y2:   state_len = YELLOW_T;
      NS_LFT, EW_LFT:               state_len = LEFT_T;
      ALL_RED:                      state_len = ALLRED_T;
      FLASH:                        state_len = FLASH_END_T;
      default:                      state_len = TICK_ONE;
    endcase
  end

  assign done     = (tick == state_len);
  assign preempt  = i_emg | i_night;
  assign cur_axis = (state >= EW_GRN && state <= EW_Y2) ? AXIS_EW : AXIS_NS;

  // Next-state, tick, pedestrian latch and served-flag logic
  always_comb begin
    state_d     = state;
    tick_d      = tick + TICK_ONE;
    pending_d   = pending | i_ped_req;
    last_axis_d = last_axis;
    srv_ew_d    = srv_ew;
    srv_ns_d    = srv_ns;

    case (state)
      // Green/blink/left are cut short straight into the axis's final yellow
      NS_GRN, NS_BLK, NS_LFT, EW_GRN, EW_BLK, EW_LFT: begin
        if (preempt) begin
          state_d = (cur_axis == AXIS_EW) ? EW_Y2 : NS_Y2;
          tick_d  = TICK_ONE;
        end else if (done) begin
          state_d = state_t'(state + 4'd1);
          tick_d  = TICK_ONE;
        end
      end
      // Yellows always run to completion before any preemption applies
      NS_Y1, NS_Y2, EW_Y1, EW_Y2: begin
        if (done) begin
          tick_d = TICK_ONE;
          if (i_emg) begin
            state_d     = ALL_RED;
            last_axis_d = cur_axis;
          end else if (i_night) begin
            state_d = FLASH;
          end else if (state == EW_Y2) begin
            state_d = NS_GRN;
          end else begin
            state_d = state_t'(state + 4'd1);
          end
        end
      end
      // Tick is held at 1 while emergency persists, then counts the clearance
      ALL_RED: begin
        if (i_emg) begin
          tick_d = TICK_ONE;
        end else if (done) begin
          state_d = (last_axis == AXIS_EW) ? NS_GRN : EW_GRN;
          tick_d  = TICK_ONE;
        end
      end
      // Night exit only at a period boundary; both exits resume with NS
      FLASH: begin
        if (i_emg) begin
          state_d     = ALL_RED;
          tick_d      = TICK_ONE;
          last_axis_d = AXIS_EW;
        end else if (done) begin
          tick_d = TICK_ONE;
          if (!i_night) begin
            state_d     = ALL_RED;
            last_axis_d = AXIS_EW;
          end
        end
      end
      default: begin
        state_d = NS_GRN;
        tick_d  = TICK_ONE;
      end
    endcase

    // Entering a green snapshots the latched request and clears it;
    // a request sampled on the entering edge is dropped
    if (state_d == NS_GRN && state != NS_GRN) begin
      srv_ew_d     = SRV_DEFAULT | pending[0];
      pending_d[0] = 1'b0;
    end
    if (state_d == EW_GRN && state != EW_GRN) begin
      srv_ns_d     = SRV_DEFAULT | pending[1];
      pending_d[1] = 1'b0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= NS_GRN;
      tick      <= TICK_ONE;
      pending   <= 2'b00;
      last_axis <= AXIS_EW;
      srv_ew    <= SRV_DEFAULT;
      srv_ns    <= SRV_DEFAULT;
    end else begin
      state     <= state_d;
      tick      <= tick_d;
      pending   <= pending_d;
      last_axis <= last_axis_d;
      srv_ew    <= srv_ew_d;
      srv_ns    <= srv_ns_d;
    end
  end

  // Head decode from state, tick and served flags
  always_comb begin
    o_ns_car = CAR_RED;
    o_ew_car = CAR_RED;
    o_ns_ped = PED_RED;
    o_ew_ped = PED_RED;
    case (state)
      NS_GRN: begin
        o_ns_car = CAR_GREEN;
        o_ew_ped = srv_ew ? PED_GREEN : PED_RED;
      end
      NS_BLK: begin
        o_ns_car = CAR_GREEN;
        o_ew_ped = srv_ew ? PED_BLINK : PED_RED;
      end
      NS_Y1, NS_Y2: o_ns_car = CAR_YELLOW;
      NS_LFT:       o_ns_car = CAR_LEFT;
      EW_GRN: begin
        o_ew_car = CAR_GREEN;
        o_ns_ped = srv_ns ? PED_GREEN : PED_RED;
      end
      EW_BLK: begin
        o_ew_car = CAR_GREEN;
        o_ns_ped = srv_ns ? PED_BLINK : PED_RED;
      end
      EW_Y1, EW_Y2: o_ew_car = CAR_YELLOW;
      EW_LFT:       o_ew_car = CAR_LEFT;
      FLASH: begin
        if (tick <= FLASH_HALF_T) begin
          o_ns_car = CAR_YELLOW;
          o_ew_car = CAR_YELLOW;
        end
      end
      default: ;
    endcase
  end

  assign o_state       = state;
  assign o_tick        = tick;
  assign o_ped_pending = pending;

endmodule
